// File: rtl/sign_narrow.sv
// sign_narrow: finds the minimum signed width of a two's-complement word.
// The word is scanned one bit per cycle, starting just below the MSB.
// The value is then narrowed to OUT_W bits, saturating when it does not fit.
// Valid/ready handshakes on both sides; only one word is in flight at a time.
module sign_narrow #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4,
  parameter int WW    = $clog2(IN_W) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_fits,
  output logic [WW-1:0]    out_width,
  output logic [7:0]       sat_cnt
);

  // The scan pointer only ever indexes bits IN_W-2 down to 0.
  localparam int PW = $clog2(IN_W);

  // Saturation codes. For OUT_W = 1 these reduce to 0 and 1 (i.e. 0 and -1).
  localparam logic [OUT_W-1:0] MIN_NEG = OUT_W'(1) << (OUT_W - 1);
  localparam logic [OUT_W-1:0] MAX_POS = ~MIN_NEG;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [IN_W-1:0]   word_reg, word_next;
  logic              sign_reg, sign_next;
  logic [PW-1:0]     ptr_reg, ptr_next;
  logic              valid_reg, valid_next;
  logic [OUT_W-1:0]  data_reg, data_next;
  logic              fits_reg, fits_next;
  logic [WW-1:0]     width_reg, width_next;
  logic [7:0]        sat_reg, sat_next;

  // Per-bit "differs from the sign bit" flags of the latched word.
  logic [IN_W-1:0]   diff;

  genvar gi;
  generate
    for (gi = 0; gi < IN_W; gi++) begin : g_diff
      assign diff[gi] = word_reg[gi] ^ sign_reg;
    end
  endgenerate

  // Scan step decode: the bit at ptr either ends the scan or the pointer moves down.
  logic              hit;
  logic              last;
  logic [WW-1:0]     min_width;
  logic              width_fits;
  logic [OUT_W-1:0]  narrowed;

  assign hit        = diff[ptr_reg];
  assign last       = (ptr_reg == '0);
  // A mismatch at bit i means bits IN_W-1..i+1 are redundant copies of the sign,
  // so the value needs bits i..0 plus one sign bit: i+2 bits in total.
  assign min_width  = hit ? (WW'(ptr_reg) + WW'(2)) : WW'(1);
  assign width_fits = (min_width <= WW'(OUT_W));
  assign narrowed   = width_fits ? word_reg[OUT_W-1:0]
                                 : (sign_reg ? MIN_NEG : MAX_POS);

  // Next-state and next-register logic for the IDLE/SCAN/DONE sequence.
  always_comb begin
    state_next = state_reg;
    word_next  = word_reg;
    sign_next  = sign_reg;
    ptr_next   = ptr_reg;
    valid_next = valid_reg;
    data_next  = data_reg;
    fits_next  = fits_reg;
    width_next = width_reg;
    sat_next   = sat_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          word_next  = in_data;
          sign_next  = in_data[IN_W-1];
          ptr_next   = PW'(IN_W - 2);
          state_next = SCAN;
        end
      end

      SCAN: begin
        if (hit || last) begin
          state_next = DONE;
          valid_next = 1'b1;
          width_next = min_width;
          fits_next  = width_fits;
          data_next  = narrowed;
        end else begin
          ptr_next = ptr_reg - PW'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
          valid_next = 1'b0;
          if (!fits_reg) begin
            sat_next = sat_reg + 8'd1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  // State and result registers; a low rst_n abandons any word in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      word_reg  <= '0;
      sign_reg  <= 1'b0;
      ptr_reg   <= '0;
      valid_reg <= 1'b0;
      data_reg  <= '0;
      fits_reg  <= 1'b0;
      width_reg <= '0;
      sat_reg   <= '0;
    end else begin
      state_reg <= state_next;
      word_reg  <= word_next;
      sign_reg  <= sign_next;
      ptr_reg   <= ptr_next;
      valid_reg <= valid_next;
      data_reg  <= data_next;
      fits_reg  <= fits_next;
      width_reg <= width_next;
      sat_reg   <= sat_next;
    end
  end

  // Accept only when idle and out of reset, so reset never swallows a word.
  assign in_ready  = rst_n && (state_reg == IDLE);
  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_fits  = fits_reg;
  assign out_width = width_reg;
  assign sat_cnt   = sat_reg;

endmodule

// File: tb/tb_sign_narrow.sv
// Self-checking bench for sign_narrow (IN_W=8, OUT_W=4).
// The driver pushes the expected result of each accepted word into a queue.
// A separate monitor pops and compares whenever the DUT delivers a result.
module tb_sign_narrow;

  localparam int IN_W  = 8;
  localparam int OUT_W = 4;
  localparam int WW    = $clog2(IN_W) + 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_fits;
  logic [WW-1:0]    out_width;
  logic [7:0]       sat_cnt;

  sign_narrow #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_fits  (out_fits),
    .out_width (out_width),
    .sat_cnt   (sat_cnt)
  );

  typedef struct {
    logic [IN_W-1:0]  word;
    logic [OUT_W-1:0] data;
    logic             fits;
    int               width;
    int               lat;
    int               acc;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         cycle  = 0;
  bit         seen   = 0;
  bit         bp_mode = 0;
  logic [7:0] model_sat = 8'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter used to measure accept-to-valid latency.
  always @(posedge clk) cycle <= cycle + 1;

  // Random backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (bp_mode) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: smallest w such that -2^(w-1) <= v <= 2^(w-1)-1.
  function automatic exp_t model(input logic [IN_W-1:0] w);
    exp_t e;
    int   v;
    int   mw;
    v  = int'($signed(w));
    mw = IN_W;
    for (int k = IN_W; k >= 1; k--) begin
      if (v >= -(1 <<< (k - 1)) && v <= (1 <<< (k - 1)) - 1) mw = k;
    end
    e.word  = w;
    e.width = mw;
    e.fits  = (mw <= OUT_W);
    if (e.fits)      e.data = w[OUT_W-1:0];
    else if (v < 0)  e.data = OUT_W'(1 << (OUT_W - 1));
    else             e.data = OUT_W'((1 << (OUT_W - 1)) - 1);
    e.lat = (mw == 1) ? IN_W - 1 : IN_W + 1 - mw;
    e.acc = 0;
    return e;
  endfunction

  // Monitor: compares every delivered result against the head of the queue.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        if (!seen) begin
          seen = 1;
          chk($sformatf("latency[%02h]", q[0].word), 32'(cycle - q[0].acc), 32'(q[0].lat));
        end
        chk("in_ready_in_done", 32'(in_ready), 32'd0);
        if (out_ready) begin
          exp_t e;
          e = q.pop_front();
          chk($sformatf("out_data[%02h]", e.word),  32'(out_data),  32'(e.data));
          chk($sformatf("out_fits[%02h]", e.word),  32'(out_fits),  32'(e.fits));
          chk($sformatf("out_width[%02h]", e.word), 32'(out_width), 32'(e.width));
          chk($sformatf("sat_cnt[%02h]", e.word),   32'(sat_cnt),   32'(model_sat));
          if (!e.fits) model_sat = model_sat + 8'd1;
          seen = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) tick();
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_fits",  32'(out_fits),  32'd0);
    chk("rst_out_width", 32'(out_width), 32'd0);
    chk("rst_sat_cnt",   32'(sat_cnt),   32'd0);
    q.delete();
    seen      = 0;
    model_sat = 8'd0;
    rst_n     = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Present one word, wait for acceptance, then scramble in_data.
  task automatic send(input logic [IN_W-1:0] w);
    exp_t e;
    int   n;
    in_data  = w;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      chk("accept_wait", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    tick();
    e     = model(w);
    e.acc = cycle;
    q.push_back(e);
    $display("send %02h -> width %0d fits %0d data %h", w, e.width, e.fits, e.data);
    in_valid = 1'b0;
    in_data  = IN_W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 500) begin
      tick();
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick();
    do_reset();

    // Directed words from the plan.
    send(8'hFA);
    drain();
    send(8'h40);
    send(8'h80);
    drain();
    chk("sat_cnt_after_two", 32'(sat_cnt), 32'd2);
    send(8'h00);
    send(8'hFF);
    drain();

    // Backpressure on 0x05, with in_data scrambled during the scan.
    begin
      int n;
      out_ready = 1'b0;
      send(8'h05);
      for (int k = 0; k < 4; k++) begin
        in_data = IN_W'($urandom);
        tick();
      end
      n = 0;
      while (!out_valid && n < 50) begin
        tick();
        n++;
      end
      for (int k = 0; k < 6; k++) begin
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_out_data",  32'(out_data),  32'h5);
        chk("bp_out_width", 32'(out_width), 32'd4);
        chk("bp_in_ready",  32'(in_ready),  32'd0);
        tick();
      end
      out_ready = 1'b1;
      tick();
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    end

    // Reset in the third scan cycle of 0x01; also clears sat_cnt (2 here).
    send(8'h01);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd0);
    chk("midrst_sat_cnt",   32'(sat_cnt),   32'd0);
    q.delete();
    seen      = 0;
    model_sat = 8'd0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrst_release_in_ready", 32'(in_ready), 32'd1);
    repeat (12) tick();
    chk("midrst_no_stale", 32'(out_valid), 32'd0);

    // Randomized words with random backpressure and idle gaps.
    bp_mode = 1;
    for (int k = 0; k < 80; k++) begin
      send(IN_W'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end
    drain();
    bp_mode = 0;
    #2;
    out_ready = 1'b1;

    // Saturation counter wrap.
    do_reset();
    for (int k = 0; k < 255; k++) send(8'h7F);
    drain();
    chk("sat_cnt_ff", 32'(sat_cnt), 32'hFF);
    send(8'h7F);
    drain();
    chk("sat_cnt_wrap", 32'(sat_cnt), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sign_narrow.md
Name: sign_narrow

Overview:
- Sequential inverse of the sign extender. Accepts an IN_W-bit two's-complement word and finds its minimum signed width by scanning redundant sign bits, one bit per cycle from the MSB down.
- Emits the value narrowed to OUT_W bits, saturating when the value does not fit.
- Sits between the datapath and narrow immediate/store fields. Valid/ready on both sides.

Parameters:
- IN_W, 8, input word width; must be at least 2.
- OUT_W, 4, narrowed output width; must satisfy 1 <= OUT_W <= IN_W.
- WW, $clog2(IN_W)+1, width of the out_width field (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept; high only in IDLE.
- in_data  input  IN_W  signed word to narrow.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  OUT_W  narrowed or saturated value.
- out_fits  output  1  1 = value representable in OUT_W bits; 0 = saturated.
- out_width  output  WW  minimum signed width of the input, from 1 to IN_W.
- sat_cnt  output  8  count of saturated results delivered.

Behaviour:
- Reset: clk and rst_n are fixed as above (one clock; synchronous, active-low reset).
  - While rst_n = 0 at a rising edge: state goes to IDLE; out_valid, out_data, out_fits, out_width and sat_cnt all go to 0.
  - in_ready is 0 while rst_n is low.
  - Reset asserted mid-scan or mid-output discards the transaction; no output is produced for it.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch in_data into word, set sign = in_data[IN_W-1] and ptr = IN_W-2, then go to SCAN.
- SCAN: one bit examined per cycle; in_ready = 0.
  - If word[ptr] != sign: min_width = ptr+2, go to DONE.
  - Else if ptr == 0: min_width = 1, go to DONE.
  - Else ptr = ptr-1.
- Latency:
  - Scan cycles N = IN_W-1-i, where i is the index of the first mismatching bit.
  - If there is no mismatch, N = IN_W-1.
  - out_valid rises N clock edges after the accept edge: minimum 1, maximum IN_W-1.
- Result, computed on the final SCAN edge:
  - out_width = min_width.
  - out_fits = (min_width <= OUT_W).
  - If it fits: out_data = word[OUT_W-1:0].
  - If sign = 0 and it does not fit: out_data = 0 followed by OUT_W-1 ones (max positive).
  - If sign = 1 and it does not fit: out_data = 1 followed by OUT_W-1 zeros (min negative).
- DONE:
  - out_valid = 1. All out_* fields are held stable while out_ready = 0.
  - On out_ready: go to IDLE, out_valid drops on the same edge.
  - If out_fits = 0, sat_cnt increments on that edge, wrapping 0xFF -> 0x00.
  - in_ready stays 0 in DONE, so there is no overlap and a new word is accepted at the earliest one cycle after the output handshake.
- Input handling:
  - in_data is ignored outside the accept edge; changes during SCAN do not affect the result.
  - in_valid asserted during SCAN or DONE is not accepted; the producer must hold it.
- Boundary cases:
  - OUT_W = IN_W: out_fits is always 1.
  - OUT_W = 1: only 0x00 and all-ones fit.

Test Plan (IN_W=8, OUT_W=4):
- Reset, then in_data=0xFA: 5 scan cycles, then out_width=4, out_fits=1, out_data=0xA, sat_cnt=0.
- 0x40: out_valid 1 edge after accept, out_width=8, out_fits=0, out_data=0x7. 0x80: out_width=8, out_data=0x8. sat_cnt=2 after both handshakes.
- 0x00 and 0xFF: 7 scan cycles each, out_width=1, out_fits=1, out_data=0x0 and 0xF respectively.
- Backpressure on 0x05:
  - Hold out_ready=0 for 6 cycles: out_valid stays 1, out_data=0x5 and out_width=4 stay stable, in_ready=0 throughout.
  - Release out_ready: in_ready=1 on the next cycle.
  - Change in_data during SCAN: result unaffected.
- Reset mid-operation:
  - Assert rst_n=0 on the 3rd scan cycle of 0x01: next edge out_valid=0, state IDLE; after release in_ready=1 and no stale result appears.
  - Reset also clears sat_cnt.
- Counter wrap: 256 saturating words (0x7F) give sat_cnt=0x00. Verify the 0xFF -> 0x00 transition.
